// File: rtl/dct_2d_sequencer.sv
// Sequencer for the 8x8 2D DCT: 8 row lines then 8 column lines, ping-ponging
// between RAM banks, with transposed write-back and a WAIT timeout.
module dct_2d_sequencer #(
  parameter int unsigned RD_LAT  = 1,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       start,
  output logic       busy,
  output logic       frame_done,
  output logic       err,
  output logic [6:0] ram_addr,
  output logic       ram_cs,
  output logic       ram_read,
  output logic       ram_write,
  output logic [2:0] in_sel,
  output logic       in_load,
  output logic       dct_start,
  input  logic       dct_done,
  output logic       out_load,
  output logic [2:0] out_sel,
  output logic       pass
);

  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  typedef enum logic [3:0] {
    S_IDLE, S_RD, S_FILL, S_GO, S_WAIT, S_LATCH, S_WR, S_NEXT, S_DONE
  } state_t;

  state_t          state, state_d;
  logic [2:0]      line, line_d, k, k_d;
  logic            pass_d, err_d;
  logic [TW-1:0]   tcnt, tcnt_d;
  logic            busy_d, frame_done_d, ram_read_d, ram_write_d;
  logic            dct_start_d, out_load_d;
  logic [6:0]      ram_addr_d;
  logic [2:0]      out_sel_d;

  // Read-return pipeline: in_load/in_sel trail each ram_read by RD_LAT cycles.
  logic            pv [RD_LAT];
  logic [2:0]      pk [RD_LAT];

  assign in_load = pv[RD_LAT-1];
  assign in_sel  = pk[RD_LAT-1];

  always_ff @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < int'(RD_LAT); i++) begin
        pv[i] <= 1'b0;
        pk[i] <= 3'd0;
      end
    end else begin
      pv[0] <= ram_read;
      pk[0] <= ram_read ? ram_addr[2:0] : 3'd0;
      for (int i = 1; i < int'(RD_LAT); i++) begin
        pv[i] <= pv[i-1];
        pk[i] <= pk[i-1];
      end
    end
  end

  // Next state, counters, and next values of the registered outputs.
  always_comb begin
    state_d = state;
    line_d  = line;
    k_d     = k;
    pass_d  = pass;
    tcnt_d  = tcnt;
    err_d   = err;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_d = S_RD;
          line_d  = 3'd0;
          k_d     = 3'd0;
          pass_d  = 1'b0;
          err_d   = 1'b0;
        end
      end
      S_RD: begin
        k_d = 3'(k + 3'd1);
        if (k == 3'd7) state_d = S_FILL;
      end
      S_FILL: begin
        if (in_load && (in_sel == 3'd7)) state_d = S_GO;
      end
      S_GO: begin
        state_d = S_WAIT;
        tcnt_d  = '0;
      end
      S_WAIT: begin
        if (dct_done) begin
          state_d = S_LATCH;
        end else if (tcnt == TW'(TIMEOUT - 1)) begin
          state_d = S_IDLE;
          err_d   = 1'b1;
        end else begin
          tcnt_d = TW'(tcnt + TW'(1));
        end
      end
      S_LATCH: begin
        state_d = S_WR;
        k_d     = 3'd0;
      end
      S_WR: begin
        k_d = 3'(k + 3'd1);
        if (k == 3'd7) state_d = S_NEXT;
      end
      S_NEXT: begin
        line_d = 3'(line + 3'd1);
        k_d    = 3'd0;
        if (line != 3'd7) begin
          state_d = S_RD;
        end else if (!pass) begin
          state_d = S_RD;
          pass_d  = 1'b1;
        end else begin
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    busy_d       = (state_d != S_IDLE);
    frame_done_d = (state_d == S_DONE);
    ram_read_d   = (state_d == S_RD);
    ram_write_d  = (state_d == S_WR);
    dct_start_d  = (state_d == S_GO);
    out_load_d   = (state_d == S_LATCH);
    out_sel_d    = ram_write_d ? k_d : 3'd0;
    ram_addr_d   = 7'd0;
    if (ram_read_d)  ram_addr_d = {pass_d, line_d, k_d};
    if (ram_write_d) ram_addr_d = {~pass_d, k_d, line_d};
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state      <= S_IDLE;
      line       <= 3'd0;
      k          <= 3'd0;
      pass       <= 1'b0;
      tcnt       <= '0;
      err        <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      ram_addr   <= 7'd0;
      ram_cs     <= 1'b0;
      ram_read   <= 1'b0;
      ram_write  <= 1'b0;
      dct_start  <= 1'b0;
      out_load   <= 1'b0;
      out_sel    <= 3'd0;
    end else begin
      state      <= state_d;
      line       <= line_d;
      k          <= k_d;
      pass       <= pass_d;
      tcnt       <= tcnt_d;
      err        <= err_d;
      busy       <= busy_d;
      frame_done <= frame_done_d;
      ram_addr   <= ram_addr_d;
      ram_cs     <= ram_read_d | ram_write_d;
      ram_read   <= ram_read_d;
      ram_write  <= ram_write_d;
      dct_start  <= dct_start_d;
      out_load   <= out_load_d;
      out_sel    <= out_sel_d;
    end
  end

endmodule
